// File: rtl/core8_pkg.sv
// Shared definitions for the 8-bit core sequencer: FSM state encodings,
// PC update selects and default widths.
package core8_pkg;

  localparam int PCW_DEF  = 8;
  localparam int BR_OFF_W = 8;
  localparam int INST_W   = 16;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_REL  = 2'b10
  } pc_sel_t;

endpackage

// File: rtl/pc_reg8.sv
// Program counter register: reset value, hold, +1, or signed relative add.
module pc_reg8
  import core8_pkg::*;
#(
  parameter int             PCW    = PCW_DEF,
  parameter logic [PCW-1:0] RST_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  pc_sel_t             sel,
  input  logic [BR_OFF_W-1:0] off,
  output logic [PCW-1:0]      pc
);

  logic [PCW-1:0] off_ext;

  // Size cast of a signed operand sign-extends; sum wraps modulo 2^PCW.
  assign off_ext = PCW'($signed(off));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RST_PC;
    end else begin
      case (sel)
        PC_INC:  pc <= pc + PCW'(1);
        PC_REL:  pc <= pc + off_ext;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_seq8.sv
// Handshaked fetch/exec/halt instruction sequencer for the 8-bit core.
// Optional retired-instruction counter enabled by FETCH_SEQ8_ICOUNT_EN.
module fetch_seq8
  import core8_pkg::*;
#(
  parameter int             PCW    = PCW_DEF,
  parameter logic [PCW-1:0] RST_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PCW-1:0]      imem_addr,
  input  logic                imem_ack,
  input  logic [INST_W-1:0]   imem_data,
  output logic [INST_W-1:0]   inst,
  output logic                ir_ie,
  output logic                ex_go,
  input  logic                ex_done,
  input  logic                br_taken,
  input  logic [BR_OFF_W-1:0] br_off,
  input  logic                halt,
  output logic                halted,
  output logic [PCW-1:0]      pc,
  output logic [1:0]          state
`ifdef FETCH_SEQ8_ICOUNT_EN
  , output logic [15:0]       icount
`endif
);

  state_t  st;
  pc_sel_t pc_sel;
  logic    retire;

  assign retire = (st == ST_EXEC) && ex_done;

  always_comb begin
    pc_sel = PC_HOLD;
    if (retire) pc_sel = br_taken ? PC_REL : PC_INC;
  end

  pc_reg8 #(.PCW(PCW), .RST_PC(RST_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .sel (pc_sel),
    .off (br_off),
    .pc  (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_FETCH;
    end else begin
      case (st)
        ST_FETCH: if (imem_ack) st <= ST_EXEC;
        ST_EXEC:  if (ex_done)  st <= halt ? ST_HALT : ST_FETCH;
        ST_HALT:  if (!halt)    st <= ST_FETCH;
        default:                st <= ST_FETCH;
      endcase
    end
  end

  // Strobes are masked by rst so a mid-fetch or mid-exec reset drives nothing.
  always_comb begin
    imem_req  = !rst && (st == ST_FETCH);
    ir_ie     = !rst && (st == ST_FETCH) && imem_ack;
    ex_go     = !rst && (st == ST_EXEC);
    halted    = (st == ST_HALT);
    imem_addr = pc;
    inst      = imem_data;
    state     = st;
  end

`ifdef FETCH_SEQ8_ICOUNT_EN
  always_ff @(posedge clk) begin
    if (rst)         icount <= '0;
    else if (retire) icount <= icount + 16'd1;
  end
`endif

endmodule

// File: doc/fetch_seq8.md
Name: fetch_seq8

Overview:
Instruction sequencer for the 8-bit core. It owns the program counter and fetches 16-bit instructions from instruction memory over a req/ack handshake. It loads each instruction into the IR via ir_ie, then strobes the execution unit and waits for its completion. It replaces the fixed two-state fetch/execute toggle with a handshaked, stall-tolerant, branch-capable sequence.

Parameters:
PCW, 8, program counter / instruction address width in bits
RST_PC, 0, PC value loaded on reset (PCW bits)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active high
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PCW  fetch address, equals current PC
imem_ack  in  1  memory has valid data on imem_data this cycle
imem_data  in  16  fetched instruction
inst  out  16  instruction to IR input bus (passthrough of imem_data)
ir_ie  out  1  IR input enable, one cycle
ex_go  out  1  execution unit enable (drives GPR write/oe, SREG ie)
ex_done  in  1  execution unit finished current instruction
br_taken  in  1  branch resolved taken; valid only with ex_done
br_off  in  8  signed PC offset; valid only with br_taken
halt  in  1  request to stop at the next instruction boundary
halted  out  1  sequencer is in HALT
pc  out  PCW  current program counter
state  out  2  current FSM state, debug

Behaviour:
- Reset is synchronous, active high, clock clk. On a posedge with rst=1: state=FETCH, pc=RST_PC.
- imem_req, ir_ie and ex_go are gated with !rst, so they are 0 during any cycle in which rst=1, including a reset asserted mid-fetch or mid-exec.
- After reset: halted=0, pc=RST_PC, state=FETCH.
- States: FETCH=2'b00, EXEC=2'b01, HALT=2'b10. Encoding 2'b11 is illegal and goes to FETCH on the next edge.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On a cycle with imem_ack=1: ir_ie=1 in the same cycle (IR captures inst at that edge); next state EXEC.
  - Ack may arrive in the first request cycle (zero wait states) or any number of cycles later.
  - halt is ignored in FETCH; a fetch in progress always completes.
- EXEC:
  - ex_go=1 every cycle in this state; imem_req=0.
  - On ex_done=1: pc <= br_taken ? pc + sign_ext(br_off) : pc + 1. Arithmetic is modulo 2^PCW; wrap-around in both directions is legal.
  - On the same ex_done cycle: next state is HALT if halt=1, otherwise FETCH.
  - Minimum instruction latency is 2 cycles: fetch with immediate ack, then ex_done in the first EXEC cycle.
- HALT:
  - halted=1; all strobes 0; pc held.
  - When halt=0 on an edge: next state FETCH at the current pc.
- Stray inputs are ignored:
  - imem_ack outside FETCH.
  - ex_done outside EXEC.
  - br_taken without ex_done.
- inst = imem_data at all times. ir_ie alone qualifies the capture.

Optional Feature:
- Macro: FETCH_SEQ8_ICOUNT_EN.
- When defined:
  - Extra output icount (16 bits), reset to 0.
  - Increments by 1, wrapping at 16'hFFFF->0, on every EXEC cycle with ex_done=1.
  - Holds in HALT.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package core8_pkg:
  - State encodings FETCH/EXEC/HALT.
  - Default PCW.
  - Sign-extension helper constant widths for br_off.
- Sub-module pc_reg8: PC register with reset value, hold, increment and relative-add select.
- The FSM stays in fetch_seq8.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), ex_done in the 1st EXEC cycle for 3 instructions -> imem_addr 0,1,2; ir_ie pulses every 2nd cycle; pc=3.
- Ack delayed 3 cycles, data 16'h1E25 -> imem_req high for 4 cycles with addr stable; ir_ie exactly 1 cycle; inst=16'h1E25 on that cycle.
- pc=8'h10, ex_done with br_taken=1, br_off=8'hFC -> pc=8'h0C; pc=8'hFF not-taken -> pc=8'h00.
- halt=1 asserted during FETCH -> fetch completes, EXEC runs to ex_done, then HALT with halted=1 and pc held; deassert halt -> FETCH at the same pc.
- rst pulsed during EXEC at pc=5 -> ex_go=0 in the rst cycle; after the edge pc=RST_PC, state=FETCH; stray ex_done in the next FETCH is ignored.
- With FETCH_SEQ8_ICOUNT_EN defined: 4 retired instructions -> icount=4; reset -> icount=0.
